branch_resolve_predict_unit: RTL and testbench

//   Parametrised branch resolution and prediction unit for the 5-stage pipeline.

---
 rtl/branch_resolve_predict_unit.sv | 179 +++++++++++++++++
 tb/tb_branch_resolve_predict_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_predict_unit.sv
// Branch resolution and 2-bit BHT direction predictor for the 5-stage pipeline.
// Resolves conditional branches in EX, trains the BHT, predicts for IF and counts branch events.
module branch_resolve_predict_unit #(
   parameter int         XLEN        = 64,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] INIT_STATE  = 2'b01,
   parameter int         CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_req,
   input  logic [XLEN-1:0]  pred_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic [XLEN-1:0]  ex_rs2,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_pred_taken,
   output logic             res_valid,
   output logic             res_taken,
   output logic             res_mispredict,
   output logic             res_illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       bht_d [BHT_ENTRIES];

   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic             res_valid_q, res_valid_d;
   logic             res_taken_q, res_taken_d;
   logic             res_mispredict_q, res_mispredict_d;
   logic             res_illegal_q, res_illegal_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             res_fire;
   logic             f3_illegal;
   logic             cond_true;
   logic             train_en;
   logic             unused_pc_bits;

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign ex_idx   = ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                             ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

   assign res_fire   = ex_valid && ex_is_branch;
   assign f3_illegal = (ex_funct3[2:1] == 2'b01);
   assign train_en   = res_fire && !f3_illegal;

   // Prediction reads the pre-update table, so a same-edge train is not visible yet.
   always_comb begin
      pred_valid_d = pred_req;
      pred_taken_d = 1'b0;
      if (pred_req) begin
         pred_taken_d = bht_q[pred_idx][1];
      end
   end

   always_comb begin
      cond_true = 1'b0;
      case (funct3_e'(ex_funct3))
         F3_BEQ:  cond_true = (ex_rs1 == ex_rs2);
         F3_BNE:  cond_true = (ex_rs1 != ex_rs2);
         F3_BLT:  cond_true = ($signed(ex_rs1) <  $signed(ex_rs2));
         F3_BGE:  cond_true = ($signed(ex_rs1) >= $signed(ex_rs2));
         F3_BLTU: cond_true = (ex_rs1 <  ex_rs2);
         F3_BGEU: cond_true = (ex_rs1 >= ex_rs2);
         default: cond_true = 1'b0;
      endcase
   end

   // Illegal funct3 resolves as not-taken, so only a taken prediction counts as a mispredict.
   always_comb begin
      res_valid_d      = res_fire;
      res_taken_d      = 1'b0;
      res_mispredict_d = 1'b0;
      res_illegal_d    = 1'b0;
      if (res_fire) begin
         if (f3_illegal) begin
            res_illegal_d    = 1'b1;
            res_mispredict_d = ex_pred_taken;
         end else begin
            res_taken_d      = cond_true;
            res_mispredict_d = (cond_true != ex_pred_taken);
         end
      end
   end

   always_comb begin
      bht_d = bht_q;
      if (train_en) begin
         if (cond_true) begin
            if (bht_q[ex_idx] != 2'b11) begin
               bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            end
         end else begin
            if (bht_q[ex_idx] != 2'b00) begin
               bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
            end
         end
      end
   end

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (cnt_clr) begin
         branch_cnt_d  = '0;
         mispred_cnt_d = '0;
      end else begin
         if (train_en && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
         end
         if (res_mispredict_d && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= INIT_STATE;
         end
         pred_valid_q     <= 1'b0;
         pred_taken_q     <= 1'b0;
         res_valid_q      <= 1'b0;
         res_taken_q      <= 1'b0;
         res_mispredict_q <= 1'b0;
         res_illegal_q    <= 1'b0;
         branch_cnt_q     <= '0;
         mispred_cnt_q    <= '0;
      end else begin
         bht_q            <= bht_d;
         pred_valid_q     <= pred_valid_d;
         pred_taken_q     <= pred_taken_d;
         res_valid_q      <= res_valid_d;
         res_taken_q      <= res_taken_d;
         res_mispredict_q <= res_mispredict_d;
         res_illegal_q    <= res_illegal_d;
         branch_cnt_q     <= branch_cnt_d;
         mispred_cnt_q    <= mispred_cnt_d;
      end
   end

   assign pred_valid     = pred_valid_q;
   assign pred_taken     = pred_taken_q;
   assign res_valid      = res_valid_q;
   assign res_taken      = res_taken_q;
   assign res_mispredict = res_mispredict_q;
   assign res_illegal    = res_illegal_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_predict_unit.sv
// Self-checking bench for branch_resolve_predict_unit: directed scenarios plus random traffic
// compared against a counter-array reference model of the predictor and resolver.
module tb_branch_resolve_predict_unit;

   localparam int XLEN    = 64;
   localparam int BHT_N   = 16;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             pred_req;
   logic [XLEN-1:0]  pred_pc;
   logic             pred_valid;
   logic             pred_taken;
   logic             ex_valid;
   logic             ex_is_branch;
   logic [2:0]       ex_funct3;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic [XLEN-1:0]  ex_pc;
   logic             ex_pred_taken;
   logic             res_valid;
   logic             res_taken;
   logic             res_mispredict;
   logic             res_illegal;
   logic             cnt_clr;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state: plain integers for the counters and the BHT.
   int bht_m [BHT_N];
   int bcnt_m;
   int mcnt_m;
   bit e_pv, e_pt, e_rv, e_rt, e_rm, e_ri;

   logic [13:0] dut_outs;
   assign dut_outs = {pred_valid, pred_taken, res_valid, res_taken, res_mispredict,
                      res_illegal, branch_cnt, mispred_cnt};

   branch_resolve_predict_unit #(
      .XLEN(XLEN), .BHT_ENTRIES(BHT_N), .INIT_STATE(2'b01), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
      .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
      .res_illegal(res_illegal), .cnt_clr(cnt_clr),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idx_of(logic [XLEN-1:0] pc);
      return int'((pc / 4) % BHT_N);
   endfunction

   function automatic bit branch_outcome(logic [2:0] f3, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      longint sa = a;
      longint sb = b;
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [13:0] exp_outs();
      return {e_pv, e_pt, e_rv, e_rt, e_rm, e_ri, CNT_W'(bcnt_m), CNT_W'(mcnt_m)};
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      bit fire, illegal, outcome;
      int ei, pi;
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++) bht_m[i] = 1;
         {e_pv, e_pt, e_rv, e_rt, e_rm, e_ri} = '0;
         bcnt_m = 0;
         mcnt_m = 0;
         return;
      end
      pi      = idx_of(pred_pc);
      ei      = idx_of(ex_pc);
      fire    = ex_valid && ex_is_branch;
      illegal = (ex_funct3 == 3'd2) || (ex_funct3 == 3'd3);
      outcome = branch_outcome(ex_funct3, ex_rs1, ex_rs2);
      e_pv = pred_req;
      e_pt = pred_req && (bht_m[pi] >= 2);
      e_rv = fire;
      e_ri = fire && illegal;
      e_rt = fire && !illegal && outcome;
      e_rm = fire && (illegal ? ex_pred_taken : (outcome != ex_pred_taken));
      if (cnt_clr) begin
         bcnt_m = 0;
         mcnt_m = 0;
      end else begin
         if (fire && !illegal) bcnt_m = (bcnt_m < CNT_MAX) ? bcnt_m + 1 : CNT_MAX;
         if (e_rm)             mcnt_m = (mcnt_m < CNT_MAX) ? mcnt_m + 1 : CNT_MAX;
      end
      if (fire && !illegal) begin
         if (outcome) bht_m[ei] = (bht_m[ei] < 3) ? bht_m[ei] + 1 : 3;
         else         bht_m[ei] = (bht_m[ei] > 0) ? bht_m[ei] - 1 : 0;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pred_req      = 1'b0;
      pred_pc       = '0;
      ex_valid      = 1'b0;
      ex_is_branch  = 1'b0;
      ex_funct3     = 3'd0;
      ex_rs1        = '0;
      ex_rs2        = '0;
      ex_pc         = '0;
      ex_pred_taken = 1'b0;
      cnt_clr       = 1'b0;
   endtask

   task automatic set_resolve(logic [2:0] f3, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                              logic [XLEN-1:0] pc, logic pt);
      ex_valid      = 1'b1;
      ex_is_branch  = 1'b1;
      ex_funct3     = f3;
      ex_rs1        = a;
      ex_rs2        = b;
      ex_pc         = pc;
      ex_pred_taken = pt;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_outs !== 14'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", dut_outs, 14'd0);
      end
      cycle();
      checks++;
      if (dut_outs !== exp_outs()) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got %h expected %h", dut_outs, exp_outs());
      end
   endtask

   task automatic test_predict_init();
      idle_inputs();
      pred_req = 1'b1;
      pred_pc  = 64'h100;
      cycle();
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
         errors++;
         $display("[TB] FAIL predict_init: got valid=%b taken=%b expected valid=1 taken=0",
                  pred_valid, pred_taken);
      end
      idle_inputs();
      cycle();
      checks++;
      if (pred_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL predict_drop: got valid=%b expected 0", pred_valid);
      end
   endtask

   task automatic test_train_beq();
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         set_resolve(3'd0, 64'd5, 64'd5, 64'h100, 1'b0);
         cycle();
         checks++;
         if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_mispredict !== 1'b1) begin
            errors++;
            $display("[TB] FAIL beq_train_%0d: got v=%b t=%b m=%b expected 1 1 1",
                     k, res_valid, res_taken, res_mispredict);
         end
      end
      idle_inputs();
      pred_req = 1'b1;
      pred_pc  = 64'h100;
      cycle();
      checks++;
      if (pred_taken !== 1'b1 || dut_outs !== exp_outs()) begin
         errors++;
         $display("[TB] FAIL beq_predict_taken: got %h expected %h", dut_outs, exp_outs());
      end
   endtask

   task automatic test_compare_types();
      logic [2:0]  f3s  [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd1};
      bit          want [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
         idle_inputs();
         set_resolve(f3s[k], '1, 64'd1, 64'h40 + 64'(k * 4), 1'b0);
         cycle();
         checks++;
         if (res_taken !== want[k] || dut_outs !== exp_outs()) begin
            errors++;
            $display("[TB] FAIL compare_f3_%0d: got taken=%b outs=%h expected taken=%b outs=%h",
                     f3s[k], res_taken, dut_outs, want[k], exp_outs());
         end
      end
   endtask

   task automatic test_collision();
      do_reset();
      idle_inputs();
      pred_req = 1'b1;
      pred_pc  = 64'h200;
      set_resolve(3'd1, 64'd1, 64'd2, 64'h200, 1'b0);
      cycle();
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
         errors++;
         $display("[TB] FAIL collision_old_value: got taken=%b expected 0", pred_taken);
      end
      idle_inputs();
      pred_req = 1'b1;
      pred_pc  = 64'h200;
      cycle();
      checks++;
      if (pred_taken !== 1'b1) begin
         errors++;
         $display("[TB] FAIL collision_update_landed: got taken=%b expected 1", pred_taken);
      end
   endtask

   task automatic test_illegal();
      logic [CNT_W-1:0] b0, m0;
      b0 = CNT_W'(bcnt_m);
      m0 = CNT_W'(mcnt_m);
      idle_inputs();
      set_resolve(3'd2, 64'd7, 64'd7, 64'h200, 1'b1);
      cycle();
      checks++;
      if (res_illegal !== 1'b1 || res_taken !== 1'b0 || res_mispredict !== 1'b1 ||
          branch_cnt !== b0 || mispred_cnt !== m0 + 1'b1) begin
         errors++;
         $display("[TB] FAIL illegal_f3: got i=%b t=%b m=%b bc=%0d mc=%0d expected 1 0 1 %0d %0d",
                  res_illegal, res_taken, res_mispredict, branch_cnt, mispred_cnt, b0, m0 + 1'b1);
      end
      idle_inputs();
      pred_req = 1'b1;
      pred_pc  = 64'h200;
      cycle();
      checks++;
      if (pred_taken !== 1'b1) begin
         errors++;
         $display("[TB] FAIL illegal_no_train: got taken=%b expected 1", pred_taken);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 20; k++) begin
         idle_inputs();
         set_resolve(3'd0, 64'(k), 64'(k), 64'h300, 1'b1);
         cycle();
      end
      checks++;
      if (branch_cnt !== 4'd15) begin
         errors++;
         $display("[TB] FAIL branch_cnt_saturate: got %0d expected 15", branch_cnt);
      end
      idle_inputs();
      set_resolve(3'd1, 64'd1, 64'd1, 64'h300, 1'b1);
      cnt_clr = 1'b1;
      cycle();
      checks++;
      if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0 || res_mispredict !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cnt_clr_wins: got bc=%0d mc=%0d m=%b expected 0 0 1",
                  branch_cnt, mispred_cnt, res_mispredict);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         idle_inputs();
         rst_n    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         pred_req = 1'($urandom);
         pred_pc  = {32'($urandom), 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3))};
         cnt_clr  = ($urandom_range(0, 99) < 3);
         ex_valid     = ($urandom_range(0, 3) != 0);
         ex_is_branch = ($urandom_range(0, 4) != 0);
         ex_funct3    = 3'($urandom);
         ex_rs1       = {32'($urandom), 32'($urandom)};
         case ($urandom_range(0, 3))
            0:       ex_rs2 = ex_rs1;
            1:       ex_rs2 = ~ex_rs1;
            default: ex_rs2 = {32'($urandom), 32'($urandom)};
         endcase
         ex_pc         = {32'($urandom), 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3))};
         ex_pred_taken = 1'($urandom);
         cycle();
         checks++;
         if (dut_outs !== exp_outs()) begin
            errors++;
            $display("[TB] FAIL random_%0d: got %h expected %h", n, dut_outs, exp_outs());
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      set_resolve(3'd0, 64'd3, 64'd3, 64'h500, 1'b0);
      cycle();
      pred_req = 1'b1;
      pred_pc  = 64'h500;
      cnt_clr  = 1'b0;
      rst_n    = 1'b0;
      cycle();
      checks++;
      if (dut_outs !== 14'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_outputs: got %h expected 0", dut_outs);
      end
      rst_n = 1'b1;
      idle_inputs();
      set_resolve(3'd0, 64'd9, 64'd9, 64'h500, 1'b0);
      cycle();
      idle_inputs();
      pred_req = 1'b1;
      pred_pc  = 64'h500;
      cycle();
      checks++;
      if (pred_taken !== 1'b1 || dut_outs !== exp_outs()) begin
         errors++;
         $display("[TB] FAIL reset_bht_init: got %h expected %h", dut_outs, exp_outs());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_predict_init();
      test_train_beq();
      test_compare_types();
      test_collision();
      test_illegal();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
